// File: rtl/mem_bank_responder.sv
// Single-port 64-bit memory bank responder with round-robin read/write arbitration.
// Latency: read data RD_LATENCY cycles after acceptance, write ack 2 cycles after acceptance.
// Backpressure: i_hold or an acceptance in the previous cycle blocks new acceptance; requests wait.
module mem_bank_responder #(
    parameter int ADDR_BITS  = 12,
    parameter int RD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rd_req,
    input  logic [23:0] i_rd_addr,
    output logic        o_rd_addr_ack,
    output logic [63:0] o_rd_data,
    output logic        o_rd_ack,
    input  logic        i_wr_req,
    input  logic [23:0] i_wr_addr,
    input  logic [63:0] i_wr_data,
    output logic        o_wr_addr_ack,
    output logic        o_wr_ack,
    input  logic        i_hold,
    output logic        o_range_err
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [63:0]           mem [DEPTH];
    logic                  can_accept;
    logic                  gnt_rd;
    logic                  gnt_wr;
    logic                  rd_oor;
    logic                  wr_oor;
    logic                  favor_wr;
    logic [ADDR_BITS-1:0]  wr_pend_idx;
    logic [63:0]           wr_pend_dat;
    logic                  wr_pend_oor;
    logic [RD_LATENCY-1:0] pipe_vld;
    logic [63:0]           pipe_dat [RD_LATENCY];

    assign rd_oor = (i_rd_addr >> ADDR_BITS) != 24'd0;
    assign wr_oor = (i_wr_addr >> ADDR_BITS) != 24'd0;

    // A pending addr_ack means a request was taken last cycle and may still be held.
    assign can_accept = !i_hold && !o_rd_addr_ack && !o_wr_addr_ack;
    assign gnt_rd     = can_accept && i_rd_req && (!i_wr_req || !favor_wr);
    assign gnt_wr     = can_accept && i_wr_req && (!i_rd_req || favor_wr);

    assign o_rd_ack  = pipe_vld[RD_LATENCY-1];
    assign o_rd_data = pipe_dat[RD_LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_rd_addr_ack <= 1'b0;
            o_wr_addr_ack <= 1'b0;
            o_wr_ack      <= 1'b0;
            o_range_err   <= 1'b0;
            favor_wr      <= 1'b0;
            pipe_vld      <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else begin
            o_rd_addr_ack <= gnt_rd;
            o_wr_addr_ack <= gnt_wr;
            o_wr_ack      <= o_wr_addr_ack;
            o_range_err   <= (gnt_rd && rd_oor) || (gnt_wr && wr_oor);
            if (gnt_rd) begin
                favor_wr <= 1'b1;
            end else if (gnt_wr) begin
                favor_wr <= 1'b0;
            end
            // Idle stages carry zero so o_rd_data is 0 whenever o_rd_ack is 0.
            pipe_vld[0] <= gnt_rd;
            pipe_dat[0] <= (gnt_rd && !rd_oor) ? mem[i_rd_addr[ADDR_BITS-1:0]] : 64'd0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    // Array and write staging are never reset; o_wr_addr_ack marks the staged write valid.
    always_ff @(posedge clk) begin
        if (gnt_wr) begin
            wr_pend_idx <= i_wr_addr[ADDR_BITS-1:0];
            wr_pend_dat <= i_wr_data;
            wr_pend_oor <= wr_oor;
        end
        if (o_wr_addr_ack && !wr_pend_oor && !rst) begin
            mem[wr_pend_idx] <= wr_pend_dat;
        end
    end

endmodule

// File: tb/tb_mem_bank_responder.sv
// Self-checking bench for mem_bank_responder: directed scenarios plus randomized traffic vs a reference model.
module tb_mem_bank_responder;

    localparam int AB = 12;
    localparam int L  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd_req = 1'b0;
    logic [23:0] i_rd_addr = '0;
    logic        o_rd_addr_ack;
    logic [63:0] o_rd_data;
    logic        o_rd_ack;
    logic        i_wr_req = 1'b0;
    logic [23:0] i_wr_addr = '0;
    logic [63:0] i_wr_data = '0;
    logic        o_wr_addr_ack;
    logic        o_wr_ack;
    logic        i_hold = 1'b0;
    logic        o_range_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] ref_mem [int];

    mem_bank_responder #(.ADDR_BITS(AB), .RD_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr), .o_rd_addr_ack(o_rd_addr_ack),
        .o_rd_data(o_rd_data), .o_rd_ack(o_rd_ack),
        .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .o_wr_addr_ack(o_wr_addr_ack), .o_wr_ack(o_wr_ack),
        .i_hold(i_hold), .o_range_err(o_range_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    function automatic bit oor(input logic [23:0] a);
        return int'(a) >= (1 << AB);
    endfunction

    function automatic logic [23:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 24'h800000 | 24'($urandom_range(0, 15));
        return 24'h100 + 24'($urandom_range(0, 15));
    endfunction

    task automatic do_reset();
        rst = 1'b1; i_rd_req = 1'b0; i_wr_req = 1'b0; i_hold = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drivers only: follow the handshake and report what they saw.
    task automatic drv_write(input logic [23:0] a, input logic [63:0] d,
                             output int lat, output logic rerr, output logic ok);
        int n;
        ok = 1'b0; lat = 0; rerr = 1'b0; n = 0;
        i_wr_req = 1'b1; i_wr_addr = a; i_wr_data = d;
        do begin @(negedge clk); n++; end while (!o_wr_addr_ack && n < 50);
        if (!o_wr_addr_ack) begin i_wr_req = 1'b0; return; end
        rerr = o_range_err; i_wr_req = 1'b0; lat = 1;
        while (!o_wr_ack && lat < 10) begin @(negedge clk); lat++; end
        ok = o_wr_ack;
        if (ok && !oor(a)) ref_mem[int'(a)] = d;
    endtask

    task automatic drv_read(input logic [23:0] a, output logic [63:0] d,
                            output int lat, output logic rerr, output logic ok);
        int n;
        ok = 1'b0; lat = 0; rerr = 1'b0; d = '0; n = 0;
        i_rd_req = 1'b1; i_rd_addr = a;
        do begin @(negedge clk); n++; end while (!o_rd_addr_ack && n < 50);
        if (!o_rd_addr_ack) begin i_rd_req = 1'b0; return; end
        rerr = o_range_err; i_rd_req = 1'b0; lat = 1;
        while (!o_rd_ack && lat < 10) begin @(negedge clk); lat++; end
        ok = o_rd_ack; d = o_rd_data;
    endtask

    task automatic test_reset();
        i_rd_req = 1'b1; i_wr_req = 1'b1; i_rd_addr = 24'h5; i_wr_addr = 24'h5;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({o_rd_addr_ack, o_rd_ack, o_wr_addr_ack, o_wr_ack, o_range_err, o_rd_data} !== 69'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got acks=%b%b%b%b err=%b data=%h want all 0",
                         o_rd_addr_ack, o_rd_ack, o_wr_addr_ack, o_wr_ack, o_range_err, o_rd_data);
            end
        end
        i_rd_req = 1'b0; i_wr_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat; logic rerr, ok; logic [63:0] d;
        drv_write(24'h123, 64'hDEADBEEF_CAFEF00D, lat, rerr, ok);
        n_tests++;
        if (!ok || lat !== 2 || rerr !== 1'b0) begin
            n_fail++; $display("FAIL wr_basic: got ok=%b lat=%0d err=%b want ok=1 lat=2 err=0", ok, lat, rerr);
        end
        drv_read(24'h123, d, lat, rerr, ok);
        n_tests++;
        if (!ok || lat !== L || d !== 64'hDEADBEEF_CAFEF00D) begin
            n_fail++; $display("FAIL rd_basic: got ok=%b lat=%0d data=%h want lat=%0d data=deadbeefcafef00d", ok, lat, d, L);
        end
    endtask

    task automatic test_arbitration();
        int lat, rd_acc, wr_acc, rd_ackc; logic rerr, ok; logic [63:0] d, rd_d;
        drv_write(24'h010, 64'hAAAA_0000_BBBB_1111, lat, rerr, ok);
        rst = 1'b1;
        i_rd_req = 1'b1; i_rd_addr = 24'h010;
        i_wr_req = 1'b1; i_wr_addr = 24'h010; i_wr_data = 64'h5;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_acc = -1; wr_acc = -1; rd_ackc = -1; rd_d = '1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (o_rd_addr_ack && rd_acc < 0) begin rd_acc = c; i_rd_req = 1'b0; end
            if (o_wr_addr_ack && wr_acc < 0) begin wr_acc = c; i_wr_req = 1'b0; end
            if (o_rd_ack && rd_ackc < 0) begin rd_ackc = c; rd_d = o_rd_data; end
        end
        n_tests++;
        if (rd_acc !== 1 || wr_acc !== 3) begin
            n_fail++; $display("FAIL arb_order: got rd_ack@%0d wr_ack@%0d want rd@1 wr@3", rd_acc, wr_acc);
        end
        n_tests++;
        if (rd_ackc !== L || rd_d !== 64'hAAAA_0000_BBBB_1111) begin
            n_fail++; $display("FAIL arb_old_data: got @%0d %h want @%0d aaaa0000bbbb1111", rd_ackc, rd_d, L);
        end
        ref_mem[16] = 64'h5;
        drv_read(24'h010, d, lat, rerr, ok);
        n_tests++;
        if (!ok || d !== 64'h5) begin
            n_fail++; $display("FAIL arb_new_data: got ok=%b %h want 5", ok, d);
        end
    endtask

    task automatic test_back_to_back();
        int lat, idx, k; logic rerr, ok;
        int cyc [4]; logic [63:0] dat [4];
        for (int a = 0; a < 4; a++) drv_write(24'(a), 64'(a), lat, rerr, ok);
        i_rd_req = 1'b1; i_rd_addr = 24'h0; idx = 0; k = 0;
        for (int c = 1; c <= 40 && k < 4; c++) begin
            @(negedge clk);
            if (o_rd_ack) begin cyc[k] = c; dat[k] = o_rd_data; k++; end
            if (o_rd_addr_ack) begin
                idx++;
                if (idx < 4) i_rd_addr = 24'(idx); else i_rd_req = 1'b0;
            end
        end
        i_rd_req = 1'b0;
        n_tests++;
        if (k !== 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d read acks want 4", k);
        end
        for (int i = 0; i < k; i++) begin
            n_tests++;
            if (dat[i] !== 64'(i) || (i > 0 && cyc[i] - cyc[i-1] !== 2)) begin
                n_fail++; $display("FAIL b2b_read%0d: got data=%h gap=%0d want data=%0d gap=2",
                                   i, dat[i], (i > 0) ? cyc[i] - cyc[i-1] : 2, i);
            end
        end
    endtask

    task automatic test_range();
        int lat; logic rerr, ok; logic [63:0] d;
        drv_write(24'h000, 64'h0000_0000_1111_2222, lat, rerr, ok);
        drv_write(24'hFFF, 64'hFFFF_0000_3333_4444, lat, rerr, ok);
        drv_read(24'h001000, d, lat, rerr, ok);
        n_tests++;
        if (!ok || lat !== L || rerr !== 1'b1 || d !== 64'h0) begin
            n_fail++; $display("FAIL range_rd: got ok=%b lat=%0d err=%b data=%h want lat=%0d err=1 data=0", ok, lat, rerr, d, L);
        end
        drv_write(24'hFFFFFF, 64'hBAD0_BAD0_BAD0_BAD0, lat, rerr, ok);
        n_tests++;
        if (!ok || lat !== 2 || rerr !== 1'b1) begin
            n_fail++; $display("FAIL range_wr: got ok=%b lat=%0d err=%b want ok=1 lat=2 err=1", ok, lat, rerr);
        end
        drv_read(24'h000, d, lat, rerr, ok);
        n_tests++;
        if (d !== ref_mem[0] || rerr !== 1'b0) begin
            n_fail++; $display("FAIL range_keep0: got %h err=%b want %h err=0", d, rerr, ref_mem[0]);
        end
        drv_read(24'hFFF, d, lat, rerr, ok);
        n_tests++;
        if (d !== ref_mem[32'hFFF] || rerr !== 1'b0) begin
            n_fail++; $display("FAIL range_keepfff: got %h err=%b want %h err=0", d, rerr, ref_mem[32'hFFF]);
        end
    endtask

    task automatic test_hold();
        int lat; logic rerr, ok;
        drv_write(24'h050, 64'h5050_5050_0A0A_0A0A, lat, rerr, ok);
        i_hold = 1'b1; i_rd_req = 1'b1; i_rd_addr = 24'h050;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (o_rd_addr_ack !== 1'b0) begin
                n_fail++; $display("FAIL hold_noack%0d: got addr_ack=%b want 0", c, o_rd_addr_ack);
            end
        end
        i_hold = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_rd_addr_ack !== 1'b1) begin
            n_fail++; $display("FAIL hold_release: got addr_ack=%b want 1", o_rd_addr_ack);
        end
        i_rd_req = 1'b0;
        repeat (L - 1) @(negedge clk);
        n_tests++;
        if (o_rd_ack !== 1'b1 || o_rd_data !== 64'h5050_5050_0A0A_0A0A) begin
            n_fail++; $display("FAIL hold_data: got ack=%b data=%h want ack=1 data=505050500a0a0a0a", o_rd_ack, o_rd_data);
        end
    endtask

    task automatic test_reset_midflight();
        int lat, n, stray; logic rerr, ok; logic [63:0] d;
        drv_write(24'h077, 64'h7777_0000_7777_1234, lat, rerr, ok);
        i_rd_req = 1'b1; i_rd_addr = 24'h077; n = 0;
        do begin @(negedge clk); n++; end while (!o_rd_addr_ack && n < 50);
        n_tests++;
        if (o_rd_addr_ack !== 1'b1) begin
            n_fail++; $display("FAIL midrst_accept: got addr_ack=%b want 1", o_rd_addr_ack);
        end
        i_rd_req = 1'b0; rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({o_rd_addr_ack, o_rd_ack, o_wr_addr_ack, o_wr_ack, o_range_err, o_rd_data} !== 69'd0) begin
                n_fail++; $display("FAIL midrst_outputs: got acks=%b%b%b%b err=%b data=%h want all 0",
                                   o_rd_addr_ack, o_rd_ack, o_wr_addr_ack, o_wr_ack, o_range_err, o_rd_data);
            end
        end
        rst = 1'b0; stray = 0;
        repeat (6) begin @(negedge clk); if (o_rd_ack) stray++; end
        n_tests++;
        if (stray !== 0) begin
            n_fail++; $display("FAIL midrst_noack: got %0d stray read acks want 0", stray);
        end
        drv_read(24'h077, d, lat, rerr, ok);
        n_tests++;
        if (!ok || d !== 64'h7777_0000_7777_1234) begin
            n_fail++; $display("FAIL midrst_keep: got ok=%b %h want 7777000077771234", ok, d);
        end
    endtask

    task automatic test_random();
        int lat; logic rerr, ok;
        logic p_rd, p_wr, p_hold, p_ack, exp_rd, exp_wr, exp_err, exp_rack, exp_wack, favor_rd;
        logic [23:0] p_ra, p_wa; logic [63:0] p_wd, exp_rdat;
        int rdq_due [$]; logic [63:0] rdq_dat [$]; int wrq_due [$];
        for (int a = 0; a < 16; a++) drv_write(24'h100 + 24'(a), {$urandom, $urandom}, lat, rerr, ok);
        do_reset();
        p_rd = 0; p_wr = 0; p_hold = 0; p_ack = 0; p_ra = '0; p_wa = '0; p_wd = '0; favor_rd = 1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            exp_rd = 0; exp_wr = 0;
            if (!p_hold && !p_ack) begin
                if (p_rd && p_wr) begin exp_rd = favor_rd; exp_wr = !favor_rd; end
                else begin exp_rd = p_rd; exp_wr = p_wr; end
            end
            if (exp_rd) favor_rd = 0; else if (exp_wr) favor_rd = 1;
            exp_err = exp_rd ? oor(p_ra) : (exp_wr ? oor(p_wa) : 1'b0);
            n_tests++;
            if (o_rd_addr_ack !== exp_rd || o_wr_addr_ack !== exp_wr || o_range_err !== exp_err) begin
                n_fail++; $display("FAIL rand_accept c%0d: got rd=%b wr=%b err=%b want rd=%b wr=%b err=%b",
                                   c, o_rd_addr_ack, o_wr_addr_ack, o_range_err, exp_rd, exp_wr, exp_err);
            end
            if (exp_rd) begin
                rdq_due.push_back(c + L - 1);
                rdq_dat.push_back(oor(p_ra) ? 64'h0 : ref_mem[int'(p_ra)]);
            end
            if (exp_wr) begin
                if (!oor(p_wa)) ref_mem[int'(p_wa)] = p_wd;
                wrq_due.push_back(c + 1);
            end
            exp_rack = rdq_due.size() > 0 && rdq_due[0] == c;
            exp_rdat = exp_rack ? rdq_dat[0] : 64'h0;
            if (exp_rack) begin void'(rdq_due.pop_front()); void'(rdq_dat.pop_front()); end
            exp_wack = wrq_due.size() > 0 && wrq_due[0] == c;
            if (exp_wack) void'(wrq_due.pop_front());
            n_tests++;
            if (o_rd_ack !== exp_rack || o_rd_data !== exp_rdat || o_wr_ack !== exp_wack) begin
                n_fail++; $display("FAIL rand_resp c%0d: got rack=%b data=%h wack=%b want rack=%b data=%h wack=%b",
                                   c, o_rd_ack, o_rd_data, o_wr_ack, exp_rack, exp_rdat, exp_wack);
            end
            if (exp_rd) i_rd_req = 1'b0;
            if (exp_wr) i_wr_req = 1'b0;
            if (c < 380) begin
                if (!i_rd_req && $urandom_range(0, 2) == 0) begin i_rd_req = 1'b1; i_rd_addr = rnd_addr(); end
                if (!i_wr_req && $urandom_range(0, 2) == 0) begin
                    i_wr_req = 1'b1; i_wr_addr = rnd_addr(); i_wr_data = {$urandom, $urandom};
                end
                i_hold = ($urandom_range(0, 5) == 0);
            end else begin
                i_hold = 1'b0;
            end
            p_rd = i_rd_req; p_wr = i_wr_req; p_hold = i_hold;
            p_ra = i_rd_addr; p_wa = i_wr_addr; p_wd = i_wr_data;
            p_ack = exp_rd || exp_wr;
        end
        n_tests++;
        if (rdq_due.size() != 0 || wrq_due.size() != 0 || i_rd_req || i_wr_req) begin
            n_fail++; $display("FAIL rand_drain: got %0d reads %0d writes outstanding, req rd=%b wr=%b want none",
                               rdq_due.size(), wrq_due.size(), i_rd_req, i_wr_req);
        end
        i_rd_req = 1'b0; i_wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_arbitration();
        test_back_to_back();
        test_range();
        test_hold();
        test_reset_midflight();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bank_responder.md
MEM_BANK_RESPONDER -- requirements
Module: mem_bank_responder

Interface
REQ-001 Parameter ADDR_BITS, default 12, number of implemented word-address bits (4096 x 64-bit words).
REQ-002 Parameter RD_LATENCY, default 2, cycles from read address acceptance to o_rd_ack; legal range 1..4.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_rd_req  input  1  read request; held by initiator until o_rd_addr_ack.
REQ-006 i_rd_addr  input  24  read word address.
REQ-007 o_rd_addr_ack  output  1  one-cycle pulse: read address accepted.
REQ-008 o_rd_data  output  64  read data; valid only while o_rd_ack=1.
REQ-009 o_rd_ack  output  1  one-cycle pulse: o_rd_data valid.
REQ-010 i_wr_req  input  1  write request; held with address and data until o_wr_addr_ack.
REQ-011 i_wr_addr  input  24  write word address.
REQ-012 i_wr_data  input  64  write data.
REQ-013 o_wr_addr_ack  output  1  one-cycle pulse: write accepted.
REQ-014 o_wr_ack  output  1  one-cycle pulse: write committed.
REQ-015 i_hold  input  1  stall: no new acceptance while 1 (refresh/bank busy).
REQ-016 o_range_err  output  1  one-cycle pulse: accepted access addressed beyond ADDR_BITS.

Function
REQ-017 Storage is a single-port 2^ADDR_BITS x 64 array; at most one access (read or write) is accepted per cycle.
REQ-018 An access is accepted in cycle T when its request is 1, i_hold=0, and it wins arbitration; the matching addr_ack is 1 in cycle T+1 only.
REQ-019 The block does not re-accept the same request in cycle T+1; the earliest next acceptance is T+2, so the initiator may drop the request upon seeing the ack.
REQ-020 Arbitration: if only one request is present, it wins; if both are present, the winner is the class not granted last time (round-robin); after reset read has priority.
REQ-021 Read accepted in T: o_rd_ack=1 and o_rd_data valid in cycle T+RD_LATENCY; o_rd_data=0 whenever o_rd_ack=0.
REQ-022 Reads return strictly in acceptance order; the pipeline holds up to RD_LATENCY in-flight reads, and i_hold does not stall in-flight reads.
REQ-023 Write accepted in T: the array is updated at the end of T+1, and o_wr_ack=1 in cycle T+2.
REQ-024 Ordering: a read accepted after a write to the same address returns the new data, including back-to-back acceptance (write T, read T+2).
REQ-025 Out-of-range (any of i_*_addr[23:ADDR_BITS] nonzero): the read returns 64'h0 with normal ack timing; the write is discarded with normal ack timing; o_range_err pulses alongside the addr_ack.
REQ-026 Addresses are not wrapped or truncated; only bits [ADDR_BITS-1:0] index the array, and only when in range.
REQ-027 A request arriving while i_hold=1 waits with no ack; arbitration resumes in the first cycle with i_hold=0.

Reset
REQ-028 While rst=1: o_rd_addr_ack, o_rd_ack, o_wr_addr_ack, o_wr_ack and o_range_err are 0; o_rd_data=0; the pipeline is empty; round-robin is set to favour read.
REQ-029 Reset mid-operation discards in-flight reads and uncommitted writes with no acks; array contents are not initialised or cleared.
REQ-030 The first acceptance can occur in the first clk edge after rst deasserts.

Verification
REQ-031 Write 0x123 <- 64'hDEADBEEF_CAFEF00D, then read 0x123 -> o_wr_ack at T+2; read o_rd_ack at T+2 (RD_LATENCY=2) with the same data.
REQ-032 i_rd_req and i_wr_req both held from reset (rd 0x010, wr 0x010 <- 64'h5) -> read is accepted first and returns the old value; the write follows 2 cycles later; a read of 0x010 then returns 64'h5.
REQ-033 Four back-to-back reads 0x000..0x003, each preloaded with its address value -> acks at 2-cycle intervals; data 0,1,2,3 in order.
REQ-034 Read 24'h001000 with ADDR_BITS=12 -> data 64'h0 and o_range_err pulse; write 24'hFFFFFF -> acked, o_range_err pulses, and locations 0x000/0xFFF are unchanged.
REQ-035 i_hold=1 for 5 cycles with a read pending -> no o_rd_addr_ack during the hold; ack occurs 1 cycle after the first i_hold=0 acceptance cycle.
REQ-036 Assert rst one cycle after a read is accepted -> no o_rd_ack ever appears for it; all outputs are 0 during reset; a post-reset read of a previously written location returns the stored data.
